// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the pc, issues one instruction-memory read at a time,
// and hands the captured word downstream over a valid/ready handshake with redirect support.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no request outstanding, nothing held
// ST_FETCH | request outstanding, response will be kept
// ST_HOLD  | instruction presented downstream, waiting for acceptance
// ST_DRAIN | request outstanding, response will be discarded (redirected)
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [31:0]       o_instr_out,
  output logic [31:0]       o_instr_pc,
  output logic [31:0]       o_pc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [31:0]         r_pc;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_instr_valid;
  logic [31:0]         r_instr_out;
  logic [31:0]         r_instr_pc;

  logic [31:0]         w_redir_pc;
  logic [31:0]         w_resume_pc;
  logic [ADDR_W-1:0]   w_launch_addr;

  // A redirect in the same cycle as a launch decision makes the new fetch use the target directly.
  assign w_redir_pc    = i_redirect_pc & 32'hFFFF_FFFC;
  assign w_resume_pc   = i_redirect ? w_redir_pc : r_pc;
  assign w_launch_addr = w_resume_pc[ADDR_W+1:2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
    end else begin
      if (i_redirect) begin
        r_pc          <= w_redir_pc;
        r_instr_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_en && !i_redirect) begin
            r_state    <= ST_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_launch_addr;
          end
        end
        ST_FETCH: begin
          if (i_mem_ack) begin
            if (i_redirect) begin
              r_state    <= i_en ? ST_FETCH : ST_IDLE;
              r_mem_req  <= i_en;
              r_mem_addr <= w_launch_addr;
            end else begin
              r_instr_out   <= i_mem_rdata;
              r_instr_pc    <= r_pc;
              r_pc          <= r_pc + 32'd4;
              r_instr_valid <= 1'b1;
              r_state       <= ST_HOLD;
              r_mem_req     <= 1'b0;
            end
          end else if (i_redirect) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (i_redirect || i_instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= i_en ? ST_FETCH : ST_IDLE;
            r_mem_req     <= i_en;
            r_mem_addr    <= w_launch_addr;
          end
        end
        ST_DRAIN: begin
          // A redirect coinciding with the ack still retires the stale request.
          if (i_mem_ack) begin
            r_state    <= i_en ? ST_FETCH : ST_IDLE;
            r_mem_req  <= i_en;
            r_mem_addr <= w_launch_addr;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instr_valid = r_instr_valid;
  assign o_instr_out   = r_instr_out;
  assign o_instr_pc    = r_instr_pc;
  assign o_pc          = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch/hold/redirect rules.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, en, redirect, instr_ready;
  logic [31:0]       redirect_pc;
  logic              mem_req, mem_ack, instr_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata, instr_out, instr_pc, pc;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_instr_valid(instr_valid), .i_instr_ready(instr_ready), .o_instr_out(instr_out),
    .o_instr_pc(instr_pc), .o_pc(pc)
  );

  // instruction memory: ack after lat cycles of a held request; spur = ack with no request
  logic [31:0] mem_data [256];
  int          lat, cnt;
  logic        spur;

  always_comb begin
    mem_ack   = mem_req ? (cnt >= lat) : spur;
    mem_rdata = mem_ack ? mem_data[mem_addr] : 32'hBAD0_0BAD;
  end

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) cnt <= 0;
    else                            cnt <= cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // model: pc, one outstanding request (maybe stale), one held instruction
  logic [31:0]       m_pc, m_out, m_ipc;
  logic [ADDR_W-1:0] m_addr;
  logic              m_req, m_stale, m_hold;

  task automatic model_update(input logic s_rst, input logic s_en, input logic s_red,
                              input logic [31:0] s_rpc, input logic s_rdy,
                              input logic s_ack, input logic [31:0] s_rdata);
    logic start;
    start = 1'b0;
    if (s_rst) begin
      m_pc = 32'h0; m_out = 32'h0; m_ipc = 32'h0; m_addr = '0;
      m_req = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
      return;
    end
    if (m_req) begin
      if (s_ack) begin
        m_req = 1'b0;
        if (!m_stale && !s_red) begin
          m_out = s_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_hold = 1'b1;
        end else begin
          start = s_en;
        end
        m_stale = 1'b0;
      end else if (s_red) begin
        m_stale = 1'b1;
      end
    end else if (m_hold) begin
      if (s_red || s_rdy) begin
        m_hold = 1'b0;
        start  = s_en;
      end
    end else begin
      start = s_en && !s_red;
    end
    if (s_red) begin
      m_pc   = {s_rpc[31:2], 2'b00};
      m_hold = 1'b0;
    end
    if (start) begin
      m_req  = 1'b1;
      m_addr = m_pc[ADDR_W+1:2];
    end
  endtask

  task automatic compare_all();
    check("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("instr_valid", 32'(instr_valid), 32'(m_hold));
    if (m_hold) begin
      check("instr_out", instr_out, m_out);
      check("instr_pc", instr_pc, m_ipc);
    end
    check("pc", pc, m_pc);
  endtask

  // one clock: drive inputs, snapshot the memory response, advance model, compare at negedge
  task automatic step(input logic t_rst, input logic t_en, input logic t_red,
                      input logic [31:0] t_rpc, input logic t_rdy);
    logic        s_ack;
    logic [31:0] s_rdata;
    rst = t_rst; en = t_en; redirect = t_red; redirect_pc = t_rpc; instr_ready = t_rdy;
    #1;
    s_ack = mem_ack; s_rdata = mem_rdata;
    @(posedge clk);
    model_update(t_rst, t_en, t_red, t_rpc, t_rdy, s_ack, s_rdata);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_data[i] = 32'(i);
    lat = 0; spur = 1'b0;
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

    // reset, then zero-wait streaming
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_out", instr_out, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_pc", pc, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 0, 0, 1);
      check("tp1_valid", 32'(instr_valid), (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 1) check("tp1_addr", 32'(mem_addr), 32'((k - 1) / 2));
      else begin
        check("tp1_ipc", instr_pc, 32'((k / 2 - 1) * 4));
        check("tp1_out", instr_out, 32'(k / 2 - 1));
      end
    end

    // 3-cycle ack delay
    lat = 3;
    for (int j = 1; j <= 4; j++) begin
      step(0, 1, 0, 0, 1);
      check("tp2_req", 32'(mem_req), 32'h1);
      check("tp2_addr", 32'(mem_addr), 32'h3);
      check("tp2_valid", 32'(instr_valid), 32'h0);
    end
    step(0, 1, 0, 0, 1);
    check("tp2_valid_after_ack", 32'(instr_valid), 32'h1);
    check("tp2_out", instr_out, 32'h3);
    check("tp2_ipc", instr_pc, 32'hC);

    // downstream stall in HOLD
    lat = 0;
    for (int j = 0; j < 5; j++) begin
      step(0, 1, 0, 0, 0);
      check("tp3_out", instr_out, 32'h3);
      check("tp3_ipc", instr_pc, 32'hC);
      check("tp3_req", 32'(mem_req), 32'h0);
      check("tp3_pc", pc, 32'h10);
    end
    step(0, 1, 0, 0, 1);
    check("tp3_resume_addr", 32'(mem_addr), 32'h4);

    // redirect while a slow fetch is outstanding
    lat = 3;
    step(0, 1, 1, 32'h102, 1);
    check("tp4_pc", pc, 32'h100);
    check("tp4_drain_addr", 32'(mem_addr), 32'h4);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    check("tp4_no_valid", 32'(instr_valid), 32'h0);
    step(0, 1, 0, 0, 1);
    check("tp4_new_addr", 32'(mem_addr), 32'h40);
    check("tp4_new_req", 32'(mem_req), 32'h1);
    lat = 0;
    step(0, 1, 0, 0, 1);
    check("tp4_ipc", instr_pc, 32'h100);
    check("tp4_out", instr_out, 32'h40);

    // redirect in HOLD with ready, then redirect in IDLE with en low
    step(0, 1, 1, 32'h20, 1);
    check("tp5_valid", 32'(instr_valid), 32'h0);
    check("tp5_addr", 32'(mem_addr), 32'h8);
    step(0, 1, 0, 0, 0);
    check("tp5_ipc", instr_pc, 32'h20);
    step(0, 0, 0, 0, 1);
    check("tp5_idle_pc", pc, 32'h24);
    step(0, 0, 1, 32'h20, 1);
    check("tp5_idle_redir_pc", pc, 32'h20);
    check("tp5_idle_req", 32'(mem_req), 32'h0);
    step(0, 0, 0, 0, 1);
    check("tp5_idle_req2", 32'(mem_req), 32'h0);

    // mem_addr wrap and pc wrap, then reset mid-fetch
    step(0, 0, 1, 32'h3FC, 1);
    step(0, 1, 0, 0, 1);
    check("tp6_addr_ff", 32'(mem_addr), 32'hFF);
    step(0, 1, 0, 0, 1);
    check("tp6_ipc_3fc", instr_pc, 32'h3FC);
    step(0, 1, 0, 0, 1);
    check("tp6_addr_00", 32'(mem_addr), 32'h0);
    step(0, 1, 0, 0, 1);
    check("tp6_ipc_400", instr_pc, 32'h400);
    step(0, 1, 1, 32'hFFFF_FFFF, 1);
    check("tp6_redir_clear", pc, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 1);
    check("tp6_pc_wrap", pc, 32'h0);
    check("tp6_ipc_top", instr_pc, 32'hFFFF_FFFC);
    lat = 3;
    step(0, 1, 0, 0, 1);
    check("tp6_fetching", 32'(mem_req), 32'h1);
    step(1, 1, 0, 0, 1);
    check("tp6_rst_req", 32'(mem_req), 32'h0);
    check("tp6_rst_addr", 32'(mem_addr), 32'h0);
    check("tp6_rst_valid", 32'(instr_valid), 32'h0);
    check("tp6_rst_out", instr_out, 32'h0);
    check("tp6_rst_ipc", instr_pc, 32'h0);
    check("tp6_rst_pc", pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 256; i++) mem_data[i] = $urandom;
    for (int c = 0; c < 4000; c++) begin
      lat  = int'($urandom_range(0, 3));
      spur = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0),
           $urandom,
           ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences reads from the word-addressed instruction memory. It issues one request at a time, captures the returned instruction word, and presents it downstream with a valid/ready handshake. It also handles control-flow redirects, including redirects that arrive while a fetch is still in flight. It sits between the instruction memory and the decode stage of the core.

Parameters:
ADDR_W, 8, word-address width of instruction memory (2^ADDR_W words; 8 gives 256 words)
RESET_PC, 32'h0000_0000, byte address loaded into pc on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  fetch enable; low = finish the current transaction, then idle
redirect  input  1  load redirect_pc; flush held or in-flight instruction
redirect_pc  input  32  byte target address; bits [1:0] ignored (forced 0)
mem_req  output  1  read request to instruction memory
mem_addr  output  ADDR_W  word index of the request
mem_ack  input  1  read data valid this cycle
mem_rdata  input  32  instruction word, valid when mem_ack=1
instr_valid  output  1  instr_out/instr_pc hold a fetched instruction
instr_ready  input  1  downstream accepts the instruction
instr_out  output  32  fetched instruction word
instr_pc  output  32  byte address of instr_out
pc  output  32  next byte address to fetch

Behaviour:
- Single clock; all state updates on the rising clk edge; rst is sampled synchronously and has top priority.
- Reset values:
  - state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0
  - instr_valid=0, instr_out=0, instr_pc=0
- FSM states: IDLE, FETCH, HOLD, DRAIN. All outputs are registered.
- Address rules:
  - mem_addr comes from a request register loaded with pc[ADDR_W+1:2] when entering FETCH.
  - mem_addr is stable while mem_req=1.
- IDLE: mem_req=0. If en=1 and redirect=0, go to FETCH next cycle.
- FETCH:
  - mem_req=1, held until mem_ack.
  - On mem_ack with no redirect: instr_out<=mem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go to HOLD, mem_req<=0.
  - Latency: instr_valid rises the cycle after mem_ack.
- HOLD:
  - instr_valid=1 and instr_out/instr_pc stable until instr_valid&instr_ready.
  - On acceptance: instr_valid<=0; next state is FETCH if en=1, else IDLE.
  - Peak throughput: one instruction per 2 cycles with a zero-wait memory.
- DRAIN:
  - mem_req stays 1 on the old mem_addr until mem_ack.
  - The returned data is discarded.
  - Next state is FETCH at the redirected pc if en=1, else IDLE.
- Redirect (priority over all except rst):
  - In every state, pc<=redirect_pc with bits [1:0] cleared, and instr_valid<=0.
  - IDLE: stay IDLE. If en=1, go to FETCH next cycle.
  - FETCH with mem_ack in the same cycle: data discarded, go to FETCH (new pc) or IDLE per en.
  - FETCH without mem_ack: go to DRAIN.
  - HOLD: the held instruction is flushed. If instr_ready was also high that cycle, the handshake still counts as completed, but the pc is taken from the redirect. Go to FETCH or IDLE per en.
  - DRAIN: update pc and stay in DRAIN. The last redirect wins.
- en deassert:
  - Never abandons an outstanding request; FETCH completes normally.
  - HOLD waits for acceptance, then goes to IDLE.
- mem_ack while in IDLE or HOLD is ignored.
- Wrap-around:
  - pc+4 wraps modulo 2^32.
  - mem_addr wraps every 4*2^ADDR_W bytes (pc=0x3FC with ADDR_W=8 gives mem_addr=0xFF; next pc=0x400 gives mem_addr=0x00).
- Reset mid-operation: any outstanding request is dropped. Instruction memory shares rst and must cancel pending reads on it.
- At most one outstanding memory request at any time.

Test Plan:
- rst=1 for 2 cycles, then en=1, zero-wait memory (mem_ack same cycle as mem_req) returning word=index -> instr_valid on alternate cycles with instr_pc 0,4,8 and instr_out 0,1,2; mem_addr 0,1,2.
- Memory with 3-cycle ack delay, instr_ready=1 -> mem_req held high, mem_addr stable for 3 cycles; instr_valid the cycle after mem_ack.
- instr_ready=0 for 5 cycles in HOLD -> instr_out/instr_pc stable, mem_req=0, pc stays at instr_pc+4; fetch resumes after acceptance.
- redirect=1, redirect_pc=0x102 while FETCH waiting (ack delay 3) -> DRAIN, old response discarded, next mem_addr=0x40, then instr_pc=0x100.
- redirect in HOLD together with instr_ready=1, redirect_pc=0x20 -> instr_valid=0 next cycle, next fetch at mem_addr=0x08; in a separate case, redirect in IDLE with en=0 -> pc=0x20, mem_req stays 0.
- ADDR_W=8, redirect_pc=0x3FC, run 2 fetches -> mem_addr 0xFF then 0x00, instr_pc 0x3FC then 0x400. Separately, assert rst mid-FETCH -> all outputs at reset values next cycle.
